// File: rtl/fetch_defs.sv
// Shared definitions for the instruction fetch unit: FSM encoding and line geometry.
package fetch_defs;
  typedef enum logic {FETCH = 1'b0, SERVE = 1'b1} fetch_state_e;

  localparam int LINE_OFF_BITS   = 3;
  localparam int WORD_SEL_BIT    = 2;
  localparam int MEM_LATENCY_DEF = 6;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: memory line port on one side, decode handshake and redirect on the other.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 64,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  mem_address;
  logic [LINE_W-1:0]  mem_data_line;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output mem_address, instr_valid, instr, instr_pc,
    input  mem_data_line, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_address, instr_valid, instr, instr_pc,
    output mem_data_line, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_line_buffer.sv
// One-line instruction buffer: holds the last fetched line, selects a word, compares tags.
module fetch_line_buffer
  import fetch_defs::*;
#(
  parameter int LINE_W  = 64,
  parameter int INSTR_W = 32,
  parameter int TAG_W   = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               capture,
  input  logic [LINE_W-1:0]  line_in,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic               word_sel,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic [INSTR_W-1:0] word,
  output logic               hit
);
  logic [LINE_W-1:0] line_buf;
  logic [TAG_W-1:0]  buf_tag;
  logic              buf_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_buf  <= '0;
      buf_tag   <= '0;
      buf_valid <= 1'b0;
    end else if (capture) begin
      line_buf  <= line_in;
      buf_tag   <= tag_in;
      buf_valid <= 1'b1;
    end
  end

  // Big-endian line: the lower-addressed word sits in the upper half.
  assign word = word_sel ? line_buf[INSTR_W-1:0] : line_buf[LINE_W-1 -: INSTR_W];
  assign hit  = buf_valid && (buf_tag == lookup_tag);
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: line fetch with fixed memory latency, one-line buffer, decode handshake, redirects.
module instruction_fetch_unit
  import fetch_defs::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                LINE_W      = 64,
  parameter int                INSTR_W     = 32,
  parameter int                MEM_LATENCY = MEM_LATENCY_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input logic                       clk,
  input logic                       rst_n,
  instruction_fetch_unit_if.master  bus
);
  localparam int TAG_W = ADDR_W - LINE_OFF_BITS;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  fetch_state_e       state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n, addr_n, rd_pc;
  logic [CNT_W-1:0]   wait_cnt, cnt_n;
  logic               capture, rd_hit;
  logic [INSTR_W-1:0] word;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag);
    return {tag, {LINE_OFF_BITS{1'b0}}};
  endfunction

  assign rd_pc = bus.redirect_pc & ~ADDR_W'(3);

  fetch_line_buffer #(.LINE_W(LINE_W), .INSTR_W(INSTR_W), .TAG_W(TAG_W)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (capture),
    .line_in    (bus.mem_data_line),
    .tag_in     (pc[ADDR_W-1:LINE_OFF_BITS]),
    .word_sel   (pc[WORD_SEL_BIT]),
    .lookup_tag (rd_pc[ADDR_W-1:LINE_OFF_BITS]),
    .word       (word),
    .hit        (rd_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      bus.mem_address <= line_addr(RESET_PC[ADDR_W-1:LINE_OFF_BITS]);
      wait_cnt        <= CNT_LOAD;
    end else begin
      state           <= state_n;
      pc              <= pc_n;
      bus.mem_address <= addr_n;
      wait_cnt        <= cnt_n;
    end
  end

  // mem_address only moves on FETCH entry; the memory times its latency from that change.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = bus.mem_address;
    cnt_n   = wait_cnt;
    capture = 1'b0;
    if (bus.redirect_valid) begin
      pc_n = rd_pc;
      if (rd_hit) begin
        state_n = SERVE;
      end else begin
        state_n = FETCH;
        addr_n  = line_addr(rd_pc[ADDR_W-1:LINE_OFF_BITS]);
        cnt_n   = CNT_LOAD;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (wait_cnt == '0) begin
            capture = 1'b1;
            state_n = SERVE;
          end else begin
            cnt_n = wait_cnt - CNT_W'(1);
          end
        end
        SERVE: begin
          if (bus.instr_ready) begin
            pc_n = pc + ADDR_W'(4);
            if (pc[WORD_SEL_BIT]) begin
              state_n = FETCH;
              addr_n  = line_addr(pc[ADDR_W-1:LINE_OFF_BITS] + TAG_W'(1));
              cnt_n   = CNT_LOAD;
            end
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  assign bus.instr_valid = (state == SERVE);
  assign bus.instr       = word;
  assign bus.instr_pc    = pc;
endmodule
